ps_framebuf_writer: RTL and testbench

- Downstream stage of the Sobel/passthrough output buffer.
- Drains 12-bit pixels from the sync output FIFO (rd/almostempty handshake, 1-cycle read latency) and writes them as a raster-ordered frame into a frame-buffer write port (BRAM/SDRAM arbiter) that applies backpressure.
- Tracks x/y position, generates linear addresses, and flags end of frame for the display/readout side.

---
 rtl/ps_framebuf_writer.sv | 160 ++++++++++++++++
 tb/tb_ps_framebuf_writer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps_framebuf_writer.sv
// Drains pixels from the sync output FIFO into a raster-ordered frame-buffer write port.
// Build option: define PS_FBW_DOUBLEBUF_EN to ping-pong frames between two banks and expose o_bank.
module ps_framebuf_writer #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_obuf_data,
  input  logic                  i_obuf_almostempty,
  output logic                  o_obuf_rd,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  input  logic                  i_wr_ready,
  output logic [9:0]            o_x,
  output logic [8:0]            o_y,
  output logic                  o_busy,
`ifdef PS_FBW_DOUBLEBUF_EN
  output logic                  o_bank,
`endif
  output logic                  o_frame_done
);

  // state  | meaning
  // IDLE   | waiting for i_enable, no reads issued
  // RUN    | draining FIFO and writing the frame
  // DONE   | single cycle after the last pixel of a frame is accepted
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [8:0] Y_LAST = 9'(V_ACTIVE - 1);

  state_t                  state_q, state_d;
  logic                    rd_d;
  logic                    rd_pend_q;
  logic [DATA_WIDTH-1:0]   skid_mem [2];
  logic                    skid_wr_ptr, skid_rd_ptr;
  logic [1:0]              skid_cnt;
  logic [9:0]              x_q;
  logic [8:0]              y_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    wr_fire;
  logic                    last_pix;
  logic [2:0]              occ_sum;

  assign o_busy       = (state_q == S_RUN);
  assign o_frame_done = (state_q == S_DONE);
  assign o_wr_en      = o_busy && (skid_cnt != 2'd0);
  assign o_wr_data    = skid_mem[skid_rd_ptr];
  assign o_x          = x_q;
  assign o_y          = y_q;
  assign wr_fire      = o_wr_en && i_wr_ready;
  assign last_pix     = (x_q == X_LAST) && (y_q == Y_LAST);
  // Count the read being issued now so the skid can never be oversubscribed during a sink stall.
  assign occ_sum      = {1'b0, skid_cnt} + {2'b00, rd_pend_q} + {2'b00, o_obuf_rd};

  always_comb begin
    state_d = state_q;
    rd_d    = 1'b0;
    unique case (state_q)
      S_IDLE:  if (i_enable) state_d = S_RUN;
      S_RUN:   if (wr_fire && last_pix) state_d = S_DONE;
      S_DONE:  state_d = i_enable ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if ((state_q == S_RUN || (state_q == S_DONE && i_enable)) &&
        !i_obuf_almostempty && (occ_sum < 3'd2))
      rd_d = 1'b1;
    if (i_flush) begin
      state_d = S_IDLE;
      rd_d    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_obuf_rd   <= 1'b0;
      rd_pend_q   <= 1'b0;
      skid_mem[0] <= '0;
      skid_mem[1] <= '0;
      skid_wr_ptr <= 1'b0;
      skid_rd_ptr <= 1'b0;
      skid_cnt    <= 2'd0;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
    end else if (i_flush) begin
      o_obuf_rd   <= 1'b0;
      rd_pend_q   <= 1'b0;
      skid_wr_ptr <= 1'b0;
      skid_rd_ptr <= 1'b0;
      skid_cnt    <= 2'd0;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
    end else begin
      o_obuf_rd <= rd_d;
      rd_pend_q <= o_obuf_rd;
      if (rd_pend_q) begin
        skid_mem[skid_wr_ptr] <= i_obuf_data;
        skid_wr_ptr           <= ~skid_wr_ptr;
      end
      if (wr_fire) skid_rd_ptr <= ~skid_rd_ptr;
      unique case ({rd_pend_q, wr_fire})
        2'b10:   skid_cnt <= skid_cnt + 2'd1;
        2'b01:   skid_cnt <= skid_cnt - 2'd1;
        default: skid_cnt <= skid_cnt;
      endcase
      if (wr_fire) begin
        if (x_q == X_LAST) begin
          x_q <= '0;
          if (y_q == Y_LAST) begin
            y_q    <= '0;
            addr_q <= '0;
          end else begin
            y_q    <= y_q + 9'd1;
            addr_q <= addr_q + ADDR_WIDTH'(1);
          end
        end else begin
          x_q    <= x_q + 10'd1;
          addr_q <= addr_q + ADDR_WIDTH'(1);
        end
      end
    end
  end

`ifdef PS_FBW_DOUBLEBUF_EN
  localparam logic [ADDR_WIDTH-1:0] FRAME_PIX = ADDR_WIDTH'(H_ACTIVE * V_ACTIVE);

  logic wr_bank_q;
  logic bank_q;

  // o_bank reports the bank just finished; writes move to the other one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_bank_q <= 1'b0;
      bank_q    <= 1'b0;
    end else if (state_q == S_DONE) begin
      bank_q    <= wr_bank_q;
      wr_bank_q <= ~wr_bank_q;
    end
  end

  assign o_bank    = bank_q;
  assign o_wr_addr = wr_bank_q ? (addr_q + FRAME_PIX) : addr_q;
`else
  assign o_wr_addr = addr_q;
`endif

endmodule

// File: tb/tb_ps_framebuf_writer.sv
// Directed bench for ps_framebuf_writer on a 4x2 frame with a behavioural FIFO source.
// Covers PS_FBW_DOUBLEBUF_EN bank alternation when the macro is defined.
module tb_ps_framebuf_writer;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int DW = 12;
  localparam int AW = 19;
  localparam int FR = H * V;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_enable;
  logic          i_flush;
  logic [DW-1:0] i_obuf_data;
  logic          i_obuf_almostempty;
  logic          o_obuf_rd;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;
  logic          i_wr_ready;
  logic [9:0]    o_x;
  logic [8:0]    o_y;
  logic          o_busy;
  logic          o_frame_done;
`ifdef PS_FBW_DOUBLEBUF_EN
  logic          o_bank;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int reads_done;
  int accepts;
  int fd_cnt = 0;
  int ae_limit;
  int rdy_ph;
  bit model_clr;
  bit occ_bad;

  ps_framebuf_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_enable(i_enable),
    .i_flush(i_flush),
    .i_obuf_data(i_obuf_data),
    .i_obuf_almostempty(i_obuf_almostempty),
    .o_obuf_rd(o_obuf_rd),
    .o_wr_en(o_wr_en),
    .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data),
    .i_wr_ready(i_wr_ready),
    .o_x(o_x),
    .o_y(o_y),
    .o_busy(o_busy),
`ifdef PS_FBW_DOUBLEBUF_EN
    .o_bank(o_bank),
`endif
    .o_frame_done(o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  // FIFO source: word n (1-based since last clear) is returned the cycle after the n-th read.
  always @(posedge i_clk) begin
    if (model_clr) begin
      reads_done <= 0;
      accepts    <= 0;
    end else begin
      if (o_obuf_rd) begin
        reads_done  <= reads_done + 1;
        i_obuf_data <= DW'(reads_done + 1);
      end
      if (o_wr_en && i_wr_ready) accepts <= accepts + 1;
    end
  end

  always @(posedge i_clk) if (o_frame_done) fd_cnt <= fd_cnt + 1;

  assign i_obuf_almostempty = (reads_done + int'(o_obuf_rd)) >= ae_limit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    i_rst     = 1'b1;
    model_clr = 1'b1;
    i_flush   = 1'b0;
    ae_limit  = 1000;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst     = 1'b0;
    model_clr = 1'b0;
  endtask

  task automatic wait_rd();
    bit seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (o_obuf_rd) seen = 1;
      else @(negedge i_clk);
    end
    chk("first_rd_seen", 32'(seen), 32'd1);
  endtask

  // Waits at negedges for the write of (ea, ed); any visible write request must carry exactly these.
  task automatic expect_write(input int ea, input int ed, input bit pat);
    bit ok  = 1;
    bit got = 0;
    int p;
    for (int n = 0; n < 50 && !got; n++) begin
      if (pat) begin
        i_wr_ready = ((rdy_ph % 4) == 0) || ((rdy_ph % 4) == 3);
        rdy_ph++;
      end
      if (o_wr_en) begin
        if (o_wr_addr !== AW'(ea) || o_wr_data !== DW'(ed)) ok = 0;
        if (i_wr_ready) got = 1;
      end
      if (reads_done - accepts + int'(o_obuf_rd) > 2) occ_bad = 1;
      @(negedge i_clk);
    end
    p = ((ea % FR) + 1) % FR;
    chk($sformatf("wr_accept_a%0d", ea), 32'(got), 32'd1);
    chk($sformatf("wr_addr_data_a%0d", ea), 32'(ok), 32'd1);
    chk($sformatf("xy_after_a%0d", ea), 32'({o_y, o_x}), 32'({9'(p / H), 10'(p % H)}));
  endtask

  initial begin
    int fd0;
    i_enable   = 1'b0;
    i_wr_ready = 1'b1;
    rdy_ph     = 0;
    occ_bad    = 0;

    // Reset state
    i_rst = 1'b1; model_clr = 1'b1; i_flush = 1'b0; ae_limit = 1000;
    @(negedge i_clk);
    chk("rst_wr_en", 32'(o_wr_en), 0);
    chk("rst_obuf_rd", 32'(o_obuf_rd), 0);
    chk("rst_busy_done", 32'({o_busy, o_frame_done}), 0);
    chk("rst_xy_addr", 32'({o_y, o_x}) | 32'(o_wr_addr), 0);
    do_reset();
    chk("idle_no_rd", 32'(o_obuf_rd), 0);

    // Frame 1: full throughput sink
    i_enable = 1'b1;
    fd0 = fd_cnt;
    wait_rd();
    @(negedge i_clk);
    chk("lat_wr_en_plus1", 32'(o_wr_en), 0);
    @(negedge i_clk);
    chk("lat_wr_en_plus2", 32'(o_wr_en), 1);
    for (int k = 0; k < FR; k++) expect_write(k, k + 1, 0);
    chk("f1_frame_done", 32'(o_frame_done), 1);
    chk("f1_xy_wrapped", 32'({o_y, o_x}), 0);
    @(negedge i_clk);
    chk("f1_done_one_cycle", 32'(o_frame_done), 0);
    chk("f1_done_count", 32'(fd_cnt - fd0), 1);

    // Frame 2: sink ready pattern 1,0,0,1
    do_reset();
    occ_bad = 0;
    rdy_ph  = 0;
    fd0     = fd_cnt;
    for (int k = 0; k < FR; k++) expect_write(k, k + 1, 1);
    chk("stall_occ_le2", 32'(occ_bad), 0);
    chk("stall_frame_done", 32'(o_frame_done), 1);
    @(negedge i_clk);
    chk("stall_done_count", 32'(fd_cnt - fd0), 1);

    // Frame 3: FIFO runs dry after 3 words
    i_wr_ready = 1'b1;
    do_reset();
    ae_limit = 3;
    for (int k = 0; k < 3; k++) expect_write(k, k + 1, 0);
    repeat (8) @(negedge i_clk);
    chk("dry_no_wr_en", 32'(o_wr_en), 0);
    chk("dry_busy", 32'(o_busy), 1);
    chk("dry_accepts", 32'(accepts), 3);
    chk("dry_xy_hold", 32'({o_y, o_x}), 32'd3);
    ae_limit = 1000;
    for (int k = 3; k < FR; k++) expect_write(k, k + 1, 0);
    chk("dry_frame_done", 32'(o_frame_done), 1);

    // Flush with reads outstanding, sink stalled
    do_reset();
    i_wr_ready = 1'b0;
    fd0 = fd_cnt;
    wait_rd();
    @(negedge i_clk);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    chk("flush_wr_en", 32'(o_wr_en), 0);
    chk("flush_obuf_rd", 32'(o_obuf_rd), 0);
    chk("flush_xy", 32'({o_y, o_x}), 0);
    chk("flush_busy", 32'(o_busy), 0);
    chk("flush_words_read", 32'(reads_done), 2);
    i_wr_ready = 1'b1;
    expect_write(0, 3, 0);
    expect_write(1, 4, 0);
    chk("flush_no_done", 32'(fd_cnt - fd0), 0);

    // Async reset mid-frame
    do_reset();
    for (int k = 0; k < 3; k++) expect_write(k, k + 1, 0);
    i_wr_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("pre_rst_busy_wr", 32'({o_busy, o_wr_en}), 32'b11);
    chk("pre_rst_addr_data", 32'({o_wr_addr, o_wr_data}), 32'({AW'(3), DW'(4)}));
    #2 i_rst = 1'b1;
    #1;
    chk("arst_busy_wr", 32'({o_busy, o_wr_en, o_obuf_rd}), 0);
    chk("arst_addr_data", 32'({o_wr_addr, o_wr_data}), 0);
    chk("arst_xy", 32'({o_y, o_x}), 0);
    @(negedge i_clk);
    i_wr_ready = 1'b1;

`ifdef PS_FBW_DOUBLEBUF_EN
    // Two frames land in alternate banks
    do_reset();
    for (int k = 0; k < FR; k++) expect_write(k, k + 1, 0);
    @(negedge i_clk);
    chk("bank_after_f1", 32'(o_bank), 0);
    for (int k = 0; k < FR; k++) expect_write(FR + k, FR + k + 1, 0);
    @(negedge i_clk);
    chk("bank_after_f2", 32'(o_bank), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
